morse_msg_buffer: RTL



---
 rtl/msg_pkg.sv | 15 +
 rtl/morse_msg_buffer_tick_timer.sv | 28 ++
 rtl/morse_msg_buffer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/msg_pkg.sv
// Shared types and constants for the Morse message buffer.
package msg_pkg;

    localparam logic [4:0] BLANK_CODE = 5'd31;
    localparam int         WINDOW     = 8;

    typedef logic [4:0] code_t;

    typedef enum logic [1:0] {
        TAIL,
        SCROLL,
        HOLD
    } state_t;

endpackage

// File: rtl/morse_msg_buffer_tick_timer.sv
// Free-running tick counter with a runtime terminal value.
// done is high for the single cycle the counter sits at its terminal value.
module tick_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic         done
);

    logic [W-1:0] cnt;

    assign done = en && (cnt == last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || done) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_msg_buffer.sv
// Morse character history with a tail view or an auto-scrolling
// 8-character window feeding the seven-segment scan driver.
module morse_msg_buffer
    import msg_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int SCROLL_TICKS = 25_000_000,
    parameter int HOLD_TICKS   = 50_000_000
) (
    input  logic                       iCLK,
    input  logic                       iRST_N,
    input  logic                       iCHAR_VALID,
    input  logic [4:0]                 iCHAR,
    input  logic                       iBACKSPACE,
    input  logic                       iCLEAR,
    input  logic                       iSCROLL_EN,
    output logic [4:0]                 char0,
    output logic [4:0]                 char1,
    output logic [4:0]                 char2,
    output logic [4:0]                 char3,
    output logic [4:0]                 char4,
    output logic [4:0]                 char5,
    output logic [4:0]                 char6,
    output logic [4:0]                 char7,
    output logic [$clog2(DEPTH+1)-1:0] oCOUNT,
    output logic                       oFULL,
    output logic                       oSCROLLING
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int OW   = $clog2(DEPTH);
    localparam int TMAX = (SCROLL_TICKS > HOLD_TICKS) ? SCROLL_TICKS : HOLD_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SCROLL_LAST = TW'(SCROLL_TICKS - 1);
    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_TICKS - 1);

    code_t         mem     [DEPTH];
    code_t         mem_nxt [DEPTH];
    code_t         win     [WINDOW];
    code_t         win_nxt [WINDOW];
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [OW-1:0] offset;
    logic [OW-1:0] offset_nxt;
    state_t        state;
    state_t        state_nxt;
    logic          full;
    logic          scrolling;

    logic          clr_acc;
    logic          bs_acc;
    logic          wr_acc;
    logic          edit;
    logic          strobe;
    logic          leave;
    logic          tmr_clr;
    logic          tmr_done;
    logic [TW-1:0] tmr_last;

    assign clr_acc = iCLEAR;
    assign bs_acc  = !iCLEAR && iBACKSPACE && (count != '0);
    assign wr_acc  = !iCLEAR && !iBACKSPACE && iCHAR_VALID;
    assign edit    = clr_acc || bs_acc || wr_acc;
    assign strobe  = iCLEAR || iBACKSPACE || iCHAR_VALID;
    assign leave   = !iSCROLL_EN || (int'(count) <= WINDOW);

    // Timer idles at zero in TAIL so a new scroll always starts fresh.
    assign tmr_clr  = edit || leave || (state == TAIL);
    assign tmr_last = (state == HOLD) ? HOLD_LAST : SCROLL_LAST;

    tick_timer #(
        .W(TW)
    ) u_timer (
        .clk  (iCLK),
        .rst_n(iRST_N),
        .clr  (tmr_clr),
        .en   (state != TAIL),
        .last (tmr_last),
        .done (tmr_done)
    );

    always_comb begin
        mem_nxt   = mem;
        count_nxt = count;
        unique case (1'b1)
            clr_acc: begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_nxt[i] = BLANK_CODE;
                end
                count_nxt = '0;
            end
            bs_acc: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i == int'(count) - 1) begin
                        mem_nxt[i] = BLANK_CODE;
                    end
                end
                count_nxt = count - 1'b1;
            end
            wr_acc: begin
                if (full) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        mem_nxt[i] = mem[i+1];
                    end
                    mem_nxt[DEPTH-1] = iCHAR;
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (i == int'(count)) begin
                            mem_nxt[i] = iCHAR;
                        end
                    end
                    count_nxt = count + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        if (edit) begin
            state_nxt  = TAIL;
            offset_nxt = '0;
        end else begin
            unique case (state)
                TAIL: begin
                    if (iSCROLL_EN && !strobe && int'(count) > WINDOW) begin
                        state_nxt  = SCROLL;
                        offset_nxt = '0;
                    end
                end
                SCROLL: begin
                    if (leave) begin
                        state_nxt  = TAIL;
                        offset_nxt = '0;
                    end else if (tmr_done) begin
                        if (int'(offset) < int'(count) - WINDOW) begin
                            offset_nxt = offset + 1'b1;
                        end else begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (leave) begin
                        state_nxt  = TAIL;
                        offset_nxt = '0;
                    end else if (tmr_done) begin
                        state_nxt  = SCROLL;
                        offset_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = TAIL;
                    offset_nxt = '0;
                end
            endcase
        end
    end

    // Window is built from next-state values so it lands with the edit.
    always_comb begin
        for (int k = 0; k < WINDOW; k++) begin
            win_nxt[k] = BLANK_CODE;
            for (int i = 0; i < DEPTH; i++) begin
                if (state_nxt == TAIL) begin
                    if (i == int'(count_nxt) - 1 - k) begin
                        win_nxt[k] = mem_nxt[i];
                    end
                end else if (i == int'(offset_nxt) + WINDOW - 1 - k) begin
                    win_nxt[k] = mem_nxt[i];
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= BLANK_CODE;
            end
            for (int k = 0; k < WINDOW; k++) begin
                win[k] <= BLANK_CODE;
            end
            count     <= '0;
            offset    <= '0;
            state     <= TAIL;
            full      <= 1'b0;
            scrolling <= 1'b0;
        end else begin
            mem       <= mem_nxt;
            win       <= win_nxt;
            count     <= count_nxt;
            offset    <= offset_nxt;
            state     <= state_nxt;
            full      <= (int'(count_nxt) == DEPTH);
            scrolling <= (state_nxt != TAIL);
        end
    end

    assign char0      = win[0];
    assign char1      = win[1];
    assign char2      = win[2];
    assign char3      = win[3];
    assign char4      = win[4];
    assign char5      = win[5];
    assign char6      = win[6];
    assign char7      = win[7];
    assign oCOUNT     = count;
    assign oFULL      = full;
    assign oSCROLLING = scrolling;

endmodule
